// File: rtl/composite_arbiter_pkg.sv
// Shared types and default widths for the composite (meta + data stream) arbiter.
package composite_arbiter_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  localparam int NUM_PORTS_DEF = 4;
  localparam int META_W_DEF    = 8;
  localparam int DATA_W_DEF    = 32;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/composite_arbiter_if.sv
// Bundled per-port meta/data inputs and merged meta/data outputs of the arbiter.
interface composite_arbiter_if
  import composite_arbiter_pkg::*;
#(
  parameter int NUM_PORTS = NUM_PORTS_DEF,
  parameter int META_W    = META_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int KEEP_W    = DATA_W / 8
);
  logic [NUM_PORTS-1:0]        in_meta_valid;
  logic [NUM_PORTS-1:0]        in_meta_ready;
  logic [NUM_PORTS*META_W-1:0] in_meta_bits;
  logic [NUM_PORTS-1:0]        in_data_valid;
  logic [NUM_PORTS-1:0]        in_data_ready;
  logic [NUM_PORTS-1:0]        in_data_last;
  logic [NUM_PORTS*DATA_W-1:0] in_data_data;
  logic [NUM_PORTS*KEEP_W-1:0] in_data_keep;

  logic                        out_meta_valid;
  logic                        out_meta_ready;
  logic [META_W-1:0]           out_meta_bits;
  logic                        out_data_valid;
  logic                        out_data_ready;
  logic                        out_data_last;
  logic [DATA_W-1:0]           out_data_data;
  logic [KEEP_W-1:0]           out_data_keep;

  modport master (
    output in_meta_valid, in_meta_bits, in_data_valid, in_data_last, in_data_data, in_data_keep,
    output out_meta_ready, out_data_ready,
    input  in_meta_ready, in_data_ready,
    input  out_meta_valid, out_meta_bits, out_data_valid, out_data_last, out_data_data, out_data_keep
  );

  modport slave (
    input  in_meta_valid, in_meta_bits, in_data_valid, in_data_last, in_data_data, in_data_keep,
    input  out_meta_ready, out_data_ready,
    output in_meta_ready, in_data_ready,
    output out_meta_valid, out_meta_bits, out_data_valid, out_data_last, out_data_data, out_data_keep
  );
endinterface

// File: rtl/composite_arbiter_rr_arbiter.sv
// Round-robin request picker: search starts at ptr_i and wraps; one-hot grant plus index.
module rr_arbiter
  import composite_arbiter_pkg::*;
#(
  parameter int NUM_PORTS = NUM_PORTS_DEF,
  parameter int IDX_W     = idx_w(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] req_i,
  input  logic [IDX_W-1:0]     ptr_i,
  input  logic                 en_i,
  output logic [NUM_PORTS-1:0] grant_o,
  output logic [IDX_W-1:0]     idx_o,
  output logic                 valid_o
);

  always_comb begin
    int p;
    p       = 0;
    grant_o = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      p = (int'(ptr_i) + k) % NUM_PORTS;
      if (en_i && !valid_o && req_i[p]) begin
        grant_o[p] = 1'b1;
        idx_o      = IDX_W'(p);
        valid_o    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/composite_arbiter.sv
// N-to-1 round-robin arbiter: meta arbitrates, winner's meta is sent once, then its data up to last.
// Define COMPOSITE_ARB_PKT_CNT_EN to add pkt_cnt_o, a count of completed packets.
module composite_arbiter
  import composite_arbiter_pkg::*;
#(
  parameter int NUM_PORTS = NUM_PORTS_DEF,
  parameter int META_W    = META_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int KEEP_W    = DATA_W / 8
) (
  input  logic                clock_i,
  input  logic                reset_ni,
  composite_arbiter_if.slave  bus
`ifdef COMPOSITE_ARB_PKT_CNT_EN
  ,
  output logic [31:0]         pkt_cnt_o
`endif
);

  localparam int IDX_W = idx_w(NUM_PORTS);

  state_e               state_q;
  logic [IDX_W-1:0]     ptr_q, ptr_d;
  logic [IDX_W-1:0]     sel_q;
  logic [META_W-1:0]    meta_q, meta_d;
  logic                 meta_pend_q;
  logic                 data_done_q;

  logic [NUM_PORTS-1:0] grant;
  logic [IDX_W-1:0]     grant_idx;
  logic                 grant_vld;
  logic                 data_act;
  logic                 meta_fire;
  logic                 last_fire;
  logic                 pkt_end;
  logic [NUM_PORTS-1:0] data_rdy;

  // Gating with reset keeps every ready low while reset is held.
  rr_arbiter #(.NUM_PORTS(NUM_PORTS), .IDX_W(IDX_W)) u_rr (
    .req_i   (bus.in_meta_valid),
    .ptr_i   (ptr_q),
    .en_i    (reset_ni && (state_q == IDLE)),
    .grant_o (grant),
    .idx_o   (grant_idx),
    .valid_o (grant_vld)
  );

  assign ptr_d  = (grant_idx == IDX_W'(NUM_PORTS - 1)) ? '0 : grant_idx + 1'b1;
  assign meta_d = bus.in_meta_bits[int'(grant_idx)*META_W +: META_W];

  assign data_act  = (state_q == BUSY) && !data_done_q;
  assign meta_fire = bus.out_meta_valid && bus.out_meta_ready;
  assign last_fire = bus.out_data_valid && bus.out_data_ready && bus.out_data_last;
  assign pkt_end   = (state_q == BUSY) && (!meta_pend_q || meta_fire) && (data_done_q || last_fire);

  assign bus.in_meta_ready  = grant;
  assign bus.out_meta_valid = (state_q == BUSY) && meta_pend_q;
  assign bus.out_meta_bits  = meta_q;

  assign bus.out_data_valid = data_act && bus.in_data_valid[sel_q];
  assign bus.out_data_last  = data_act && bus.in_data_last[sel_q];
  assign bus.out_data_data  = data_act ? bus.in_data_data[int'(sel_q)*DATA_W +: DATA_W] : '0;
  assign bus.out_data_keep  = data_act ? bus.in_data_keep[int'(sel_q)*KEEP_W +: KEEP_W] : '0;

  always_comb begin
    data_rdy        = '0;
    data_rdy[sel_q] = data_act && bus.out_data_ready;
  end
  assign bus.in_data_ready = data_rdy;

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      sel_q       <= '0;
      meta_q      <= '0;
      meta_pend_q <= 1'b0;
      data_done_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_vld) begin
            state_q     <= BUSY;
            sel_q       <= grant_idx;
            meta_q      <= meta_d;
            meta_pend_q <= 1'b1;
            data_done_q <= 1'b0;
            ptr_q       <= ptr_d;
          end
        end
        BUSY: begin
          if (meta_fire) meta_pend_q <= 1'b0;
          if (last_fire) data_done_q <= 1'b1;
          if (pkt_end)   state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef COMPOSITE_ARB_PKT_CNT_EN
  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni)    pkt_cnt_o <= '0;
    else if (pkt_end) pkt_cnt_o <= pkt_cnt_o + 32'd1;
  end
`endif

endmodule

// File: tb/tb_composite_arbiter.sv
// Scoreboard bench for composite_arbiter: drivers push expected packets, a negedge monitor pops and compares.
module tb_composite_arbiter;
  import composite_arbiter_pkg::*;

  localparam int NP = 4;
  localparam int MW = 8;
  localparam int DW = 32;
  localparam int KW = 4;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic          last;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  composite_arbiter_if #(.NUM_PORTS(NP), .META_W(MW), .DATA_W(DW), .KEEP_W(KW)) bus ();

`ifdef COMPOSITE_ARB_PKT_CNT_EN
  logic [31:0] pkt_cnt;
`endif

  composite_arbiter #(.NUM_PORTS(NP), .META_W(MW), .DATA_W(DW), .KEEP_W(KW)) dut (
    .clock_i  (clk),
    .reset_ni (rst_n),
    .bus      (bus)
`ifdef COMPOSITE_ARB_PKT_CNT_EN
    ,
    .pkt_cnt_o(pkt_cnt)
`endif
  );

  logic [MW-1:0] exp_meta[$];
  beat_t         exp_data[$];
  beat_t         mon_e;
  int n_checks = 0;
  int n_pass   = 0;
  bit sb_en    = 1'b1;
  bit bp_en    = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic fail_chk(input string name, input string msg);
    n_checks++;
    $display("FAIL %s: %s", name, msg);
  endtask

  function automatic logic [MW-1:0] mk_meta(input int it, input int p);
    return MW'((it << 4) | p);
  endfunction

  function automatic logic [DW-1:0] mk_data(input int tid, input int it, input int p);
    return DW'((tid << 16) | (it << 8) | p);
  endfunction

  function automatic logic [KW-1:0] mk_keep(input int p);
    return KW'(8 | p);
  endfunction

  task automatic exp_pkt(input int p, input int it, input int nb, input int tid);
    beat_t b;
    exp_meta.push_back(mk_meta(it, p));
    for (int k = 0; k < nb; k++) begin
      b.data = mk_data(tid, it, p);
      b.keep = mk_keep(p);
      b.last = (k == nb - 1);
      exp_data.push_back(b);
    end
  endtask

  // Output readies: always 1, or random per cycle while bp_en is set.
  always @(posedge clk) begin
    #1;
    bus.out_meta_ready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
    bus.out_data_ready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  always @(negedge clk) begin
    if (rst_n && sb_en) begin
      if (bus.out_meta_valid && bus.out_meta_ready) begin
        if (exp_meta.size() == 0) fail_chk("meta_extra", $sformatf("unexpected meta 0x%0h", bus.out_meta_bits));
        else chk("out_meta_bits", 64'(bus.out_meta_bits), 64'(exp_meta.pop_front()));
      end
      if (bus.out_data_valid && bus.out_data_ready) begin
        if (exp_data.size() == 0) fail_chk("data_extra", $sformatf("unexpected beat 0x%0h", bus.out_data_data));
        else begin
          mon_e = exp_data.pop_front();
          chk("out_data_data", 64'(bus.out_data_data), 64'(mon_e.data));
          chk("out_data_keep", 64'(bus.out_data_keep), 64'(mon_e.keep));
          chk("out_data_last", 64'(bus.out_data_last), 64'(mon_e.last));
        end
      end
    end
  end

  task automatic clear_inputs();
    bus.in_meta_valid = '0;
    bus.in_meta_bits  = '0;
    bus.in_data_valid = '0;
    bus.in_data_last  = '0;
    bus.in_data_data  = '0;
    bus.in_data_keep  = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic send_meta(input int p, input logic [MW-1:0] b);
    bit hs = 1'b0;
    int t  = 0;
    bus.in_meta_bits[p*MW +: MW] = b;
    bus.in_meta_valid[p] = 1'b1;
    while (!hs && t < 3000) begin
      @(negedge clk);
      hs = bus.in_meta_ready[p];
      @(posedge clk);
      #1;
      t++;
    end
    bus.in_meta_valid[p] = 1'b0;
    if (!hs) fail_chk("meta_hs_timeout", $sformatf("port %0d meta never accepted", p));
  endtask

  task automatic send_data(input int p, input int nb, input logic [DW-1:0] d, input int dly);
    bit hs;
    int t;
    if (dly > 0) begin
      repeat (dly) @(posedge clk);
      #1;
    end
    for (int k = 0; k < nb; k++) begin
      hs = 1'b0;
      t  = 0;
      bus.in_data_data[p*DW +: DW] = d;
      bus.in_data_keep[p*KW +: KW] = mk_keep(p);
      bus.in_data_last[p]  = (k == nb - 1);
      bus.in_data_valid[p] = 1'b1;
      while (!hs && t < 3000) begin
        @(negedge clk);
        hs = bus.in_data_ready[p];
        @(posedge clk);
        #1;
        t++;
      end
      if (!hs) fail_chk("data_hs_timeout", $sformatf("port %0d beat %0d never accepted", p, k));
    end
    bus.in_data_valid[p] = 1'b0;
    bus.in_data_last[p]  = 1'b0;
  endtask

  task automatic run_port(input int p, input int npk, input int nb, input int tid, input int ddly);
    for (int it = 0; it < npk; it++) begin
      fork
        send_meta(p, mk_meta(it, p));
        send_data(p, nb, mk_data(tid, it, p), ddly);
      join
    end
  endtask

  task automatic drain(input string name);
    int t = 0;
    while ((exp_meta.size() != 0 || exp_data.size() != 0) && t < 2000) begin
      @(posedge clk);
      t++;
    end
    repeat (2) @(posedge clk);
    #1;
    chk({name, "_drained"}, 64'(exp_meta.size() + exp_data.size()), 64'd0);
    chk({name, "_meta_idle"}, 64'(bus.out_meta_valid), 64'd0);
  endtask

  // Four ports each sending npk packets of nb beats; expected grant order is 0,1,2,3 per round.
  task automatic rr_test(input string name, input int npk, input int nb, input int tid);
    do_reset();
    for (int it = 0; it < npk; it++)
      for (int p = 0; p < NP; p++) exp_pkt(p, it, nb, tid);
    fork
      run_port(0, npk, nb, tid, 0);
      run_port(1, npk, nb, tid, 0);
      run_port(2, npk, nb, tid, 0);
      run_port(3, npk, nb, tid, 0);
    join
    drain(name);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_inputs();
    rst_n = 1'b0;
    bus.in_meta_valid = 4'b1111;
    #2;
    chk("rst_in_meta_ready", 64'(bus.in_meta_ready), 64'd0);
    chk("rst_out_meta_valid", 64'(bus.out_meta_valid), 64'd0);
    chk("rst_out_data_valid", 64'(bus.out_data_valid), 64'd0);
    chk("rst_out_meta_bits", 64'(bus.out_meta_bits), 64'd0);

    rr_test("basic", 1, 1, 0);
`ifdef COMPOSITE_ARB_PKT_CNT_EN
    chk("pkt_cnt_basic", 64'(pkt_cnt), 64'd4);
`endif
    rr_test("multi", 1, 3, 1);
    rr_test("rr_1beat", 4, 1, 2);
    rr_test("rr_3beat", 3, 3, 3);
`ifdef COMPOSITE_ARB_PKT_CNT_EN
    chk("pkt_cnt_rr", 64'(pkt_cnt), 64'd12);
`endif

    // Sparse: only ports 1 and 3, first with immediate data, then with data 10 cycles late.
    do_reset();
    exp_pkt(1, 0, 2, 4);
    exp_pkt(3, 0, 2, 4);
    fork
      run_port(1, 1, 2, 4, 0);
      run_port(3, 1, 2, 4, 0);
    join
    drain("sparse");
    do_reset();
    exp_pkt(1, 0, 2, 5);
    exp_pkt(3, 0, 2, 5);
    fork
      run_port(1, 1, 2, 5, 10);
      run_port(3, 1, 2, 5, 10);
      begin
        repeat (5) @(negedge clk);
        chk("late_wait_dvalid", 64'(bus.out_data_valid), 64'd0);
        chk("late_wait_meta3_rdy", 64'(bus.in_meta_ready[3]), 64'd0);
      end
    join
    drain("sparse_late");

    // Early data on port 2 while port 3 (meta only) holds the grant.
    do_reset();
    exp_pkt(3, 0, 2, 6);
    exp_pkt(2, 0, 4, 6);
    fork
      send_meta(3, mk_meta(0, 3));
      send_data(2, 4, mk_data(6, 0, 2), 0);
      begin
        repeat (10) @(posedge clk);
        #1;
        fork
          send_meta(2, mk_meta(0, 2));
          send_data(3, 2, mk_data(6, 0, 3), 0);
        join
      end
      begin
        repeat (4) @(negedge clk);
        repeat (3) begin
          @(negedge clk);
          chk("early_rdy2_stall", 64'(bus.in_data_ready[2]), 64'd0);
          chk("early_no_dvalid", 64'(bus.out_data_valid), 64'd0);
        end
      end
    join
    drain("early");

    bp_en = 1'b1;
    rr_test("backpressure", 2, 3, 7);
    bp_en = 1'b0;

    // Reset mid-packet: port 0 streaming, ports 0 and 2 holding meta valid.
    do_reset();
    sb_en = 1'b0;
    bus.in_meta_bits[0*MW +: MW]  = 8'hAA;
    bus.in_meta_bits[2*MW +: MW]  = 8'hBB;
    bus.in_meta_valid[0]          = 1'b1;
    bus.in_data_data[0*DW +: DW]  = 32'h1234_5678;
    bus.in_data_keep[0*KW +: KW]  = 4'hF;
    bus.in_data_valid[0]          = 1'b1;
    @(posedge clk);
    #1 bus.in_meta_valid[0] = 1'b0;
    bus.in_meta_valid = 4'b0101;
    repeat (3) @(posedge clk);
    #2;
    chk("pre_rst_dvalid", 64'(bus.out_data_valid), 64'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_dvalid", 64'(bus.out_data_valid), 64'd0);
    chk("mid_rst_mvalid", 64'(bus.out_meta_valid), 64'd0);
    chk("mid_rst_in_drdy", 64'(bus.in_data_ready), 64'd0);
    chk("mid_rst_in_mrdy", 64'(bus.in_meta_ready), 64'd0);
    chk("mid_rst_mbits", 64'(bus.out_meta_bits), 64'd0);
    chk("mid_rst_ddata", 64'(bus.out_data_data), 64'd0);
`ifdef COMPOSITE_ARB_PKT_CNT_EN
    chk("mid_rst_pkt_cnt", 64'(pkt_cnt), 64'd0);
`endif
    clear_inputs();
    @(posedge clk);
    #1 rst_n = 1'b1;
    sb_en = 1'b1;
    exp_pkt(0, 0, 2, 8);
    exp_pkt(2, 0, 2, 8);
    fork
      run_port(0, 1, 2, 8, 0);
      run_port(2, 1, 2, 8, 0);
    join
    drain("post_rst");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/composite_arbiter.md
Name: composite_arbiter

Overview:
- N-to-1 round-robin arbiter for composite (meta + data-stream) traffic.
- Each input port has an 8-bit meta channel and an AXI-Stream-like data channel (last/data/keep).
- Arbitration is driven by meta. The winning port's meta is forwarded once, then its data beats are forwarded up to and including the `last` beat.
- Sits in front of any single consumer of command-plus-payload packets, e.g. a shared network or DMA transmit path.

Parameters:
- NUM_PORTS, 4, number of input ports (≥2).
- META_W, 8, meta payload width.
- DATA_W, 32, data beat width.
- KEEP_W, DATA_W/8, byte-enable width.

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_meta_valid  in  NUM_PORTS  per-port meta valid.
- in_meta_ready  out  NUM_PORTS  per-port meta ready.
- in_meta_bits  in  NUM_PORTS*META_W  per-port meta; port i occupies slice [i*META_W +: META_W].
- in_data_valid  in  NUM_PORTS  per-port data valid.
- in_data_ready  out  NUM_PORTS  per-port data ready.
- in_data_last  in  NUM_PORTS  per-port end-of-packet flag.
- in_data_data  in  NUM_PORTS*DATA_W  per-port beat data.
- in_data_keep  in  NUM_PORTS*KEEP_W  per-port byte enables.
- out_meta_valid/out_meta_ready/out_meta_bits  out/in/out  1/1/META_W  merged meta stream.
- out_data_valid/out_data_ready  out/in  1/1  merged data handshake.
- out_data_last/out_data_data/out_data_keep  out  1/DATA_W/KEEP_W  merged data beat.

Behaviour:
- Handshake: a transfer occurs on valid & ready at the rising clock edge. Inputs may hold valid without ready. Bits are stable while valid is high and ready is low.
- Reset (reset=0, asynchronous):
  - State is IDLE and the RR pointer is 0, so port 0 has highest priority.
  - out_meta_valid=0, out_data_valid=0, all in_*_ready=0, meta register=0, sel=0.
- State IDLE:
  - Pick winner i among ports with in_meta_valid. Search starts at the port after the last grant (ptr) and wraps.
  - Assert in_meta_ready[i] combinationally in that cycle and load meta register = in_meta_bits[i].
  - Set sel=i, meta_pend=1, data_done=0, ptr=(i+1) mod NUM_PORTS, then go to BUSY.
  - Data validity is not needed to win; meta alone arbitrates.
- State BUSY:
  - out_meta_valid = meta_pend and out_meta_bits = meta register. meta_pend clears when out_meta fires.
  - Data path is combinational from port sel while data_done=0:
    - out_data_valid = in_data_valid[sel]
    - in_data_ready[sel] = out_data_ready
    - last/data/keep are muxed from port sel.
  - data_done sets when a beat with last=1 fires. After that, out_data_valid=0 and in_data_ready[sel]=0.
  - Data beats may be forwarded before the meta handshake completes; meta and data are independent.
  - Exit to IDLE in the cycle where meta_pend and !data_done are both resolved, including both resolving in the same cycle.
- Per-packet overhead: one IDLE arbitration cycle. Meta appears one cycle after in_meta fires.
- Non-selected ports always see in_data_ready=0 and in_meta_ready=0; data arriving early on a non-granted port stalls.
- A granted port whose data has not yet arrived blocks the arbiter until its `last` beat fires. No timeout.
- No ports valid in IDLE: stay in IDLE, ptr unchanged.
- Single-beat packets (last on first beat) are legal.

Optional Feature:
- Macro COMPOSITE_ARB_PKT_CNT_EN.
  - Defined: adds output port pkt_cnt (32 bits). It is reset to 0 and increments by 1 on every BUSY→IDLE transition, wrapping at 2^32.
  - Undefined: port and counter are absent; all other behaviour is identical.

Decomposition:
- Package composite_arbiter_pkg: state enum {IDLE, BUSY} and default width constants (META_W=8, DATA_W=32).
- One sub-module, rr_arbiter (NUM_PORTS):
  - Takes request vector, pointer and enable.
  - Returns a one-hot grant plus index.
  - The top level owns the pointer update.

Test Plan:
- Basic: meta0..3 = 0x00..0x03 and single-beat data 0..3 (last=1) all presented together → out_meta 0,1,2,3 in order, each followed by its one data beat with data=port index.
- Multi-beat: each port sends meta plus 3 beats (last on the 3rd) → per packet, out_data carries exactly 3 consecutive beats with an identical data value; no interleaving.
- Round-robin fairness: 4 single-beat packets queued per port → out_meta sequence 0,1,2,3 repeated four times. Repeat with 3-beat packets ×3 → 0,1,2,3 ×3.
- Sparse/ordering: only ports 1 and 3 send meta plus 2 beats; also send meta first and data 100 ns later → order is 1 then 3 in both cases; the arbiter waits in BUSY for the late data.
- Early data on a non-granted port: meta3 plus 4 beats on data2, then 100 ns later meta2 plus 2 beats on data3 → port 3 is granted first with data2 stalled (in_data_ready[2]=0), then port 2 with 4 beats.
- Backpressure and reset: toggle out_meta_ready and out_data_ready randomly → no loss or duplication. Assert reset mid-packet → all outputs 0 immediately; after release, grant restarts at port 0.
